// File: rtl/mic_pkg.sv
// Shared definitions for the PDM microphone array frame scheduler.
// Contents: scheduler state enum, default channel count / sample width,
// and chan_w() which sizes a channel-index field for a given channel count.
package mic_pkg;

    localparam int unsigned NCH_DEF = 4;
    localparam int unsigned DW_DEF  = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWarmup = 2'd1,
        StWait   = 2'd2,
        StDrain  = 2'd3
    } mic_sched_state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mic_next_chan.sv
// Combinational channel walker.
// Returns the lowest set bit of mask strictly above cur, or the lowest set
// bit overall when from_start is high (cur treated as -1).
// Ports:
//   mask       enabled-channel mask
//   cur        current channel index
//   from_start ignore cur and search from channel 0
//   nxt        next enabled channel (0 when none)
//   none       no enabled channel found
module mic_next_chan #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 2
) (
    input  logic [NCH-1:0] mask,
    input  logic [CW-1:0]  cur,
    input  logic           from_start,
    output logic [CW-1:0]  nxt,
    output logic           none
);

    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = 0; i < int'(NCH); i++) begin
            if (none && mask[i] && (from_start || (i > int'(cur)))) begin
                nxt  = CW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mic_frame_sched.sv
// Frame scheduler for the PDM microphone array.
// On each ce_pcm strobe it snapshots every enabled channel's PCM sample and
// serialises them, lowest channel first, onto a valid/ready stream. Discards
// warmup_frames frames after enable and flags frames lost to back-pressure.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   en                scheduler enable (low forces idle)
//   warmup_frames     frames discarded after enable
//   ch_mask           channel enable mask, sampled when a frame is accepted
//   ce_pcm, pcm_in    frame strobe and packed per-channel samples
//   m_valid/m_ready   output handshake
//   m_data/m_chan     sample and its channel index
//   m_last            final sample of the frame
//   overrun, ovr_clr  sticky dropped-frame flag and its clear
//   busy              high while warming up or draining
module mic_frame_sched
    import mic_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned DW  = DW_DEF,
    localparam int unsigned CW = chan_w(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        warmup_frames,
    input  logic [NCH-1:0]    ch_mask,
    input  logic              ce_pcm,
    input  logic [NCH*DW-1:0] pcm_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [CW-1:0]     m_chan,
    output logic              m_last,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              busy
);

    mic_sched_state_t  state_q, state_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [NCH*DW-1:0] hold_q, hold_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic [DW-1:0]     data_q, data_d;
    logic [CW-1:0]     chan_q, chan_d;
    logic              last_q, last_d;
    logic              ovr_q, ovr_d;

    logic [NCH-1:0]    nc_mask;
    logic              nc_start;
    logic [CW-1:0]     nc_next;
    logic              nc_none;
    logic [CW-1:0]     hi_chan;

    // In WAIT the walker looks at the live mask to find the first channel;
    // in DRAIN it walks the snapshot from the channel currently presented.
    assign nc_mask  = (state_q == StDrain) ? mask_q : ch_mask;
    assign nc_start = (state_q != StDrain);

    mic_next_chan #(
        .NCH (NCH),
        .CW  (CW)
    ) u_next_chan (
        .mask       (nc_mask),
        .cur        (chan_q),
        .from_start (nc_start),
        .nxt        (nc_next),
        .none       (nc_none)
    );

    // Highest enabled channel of the same mask; marks the last beat.
    always_comb begin
        hi_chan = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (nc_mask[i]) begin
                hi_chan = CW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        hold_d  = hold_q;
        mask_d  = mask_q;
        data_d  = data_q;
        chan_d  = chan_q;
        last_d  = last_q;
        // A strobe while draining is dropped, even on the final handshake.
        ovr_d   = (ovr_q & ~ovr_clr) | ((state_q == StDrain) & ce_pcm);

        if (!en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wcnt_d  = warmup_frames;
                    state_d = (warmup_frames == 8'd0) ? StWait : StWarmup;
                end
                StWarmup: begin
                    if (ce_pcm) begin
                        wcnt_d = wcnt_q - 8'd1;
                        if (wcnt_q <= 8'd1) begin
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    if (ce_pcm && !nc_none) begin
                        hold_d  = pcm_in;
                        mask_d  = ch_mask;
                        chan_d  = nc_next;
                        data_d  = pcm_in[32'(nc_next) * DW +: DW];
                        last_d  = (nc_next == hi_chan);
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (m_ready) begin
                        if (last_q) begin
                            state_d = StWait;
                        end else begin
                            chan_d = nc_next;
                            data_d = hold_q[32'(nc_next) * DW +: DW];
                            last_d = (nc_next == hi_chan);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            hold_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hold_q  <= hold_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
            ovr_q   <= ovr_d;
        end
    end

    // Pure decodes of registered state: nothing combinational from m_ready.
    assign m_valid = (state_q == StDrain);
    assign busy    = (state_q == StDrain) || (state_q == StWarmup);
    assign m_data  = data_q;
    assign m_chan  = chan_q;
    assign m_last  = last_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_mic_frame_sched.sv
// Self-checking bench for mic_frame_sched: directed scenarios followed by a
// randomised phase, all checked every cycle against a frame-level model.
module tb_mic_frame_sched;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 16;

    logic              clk;
    logic              rst;
    logic              en;
    logic [7:0]        warmup_frames;
    logic [NCH-1:0]    ch_mask;
    logic              ce_pcm;
    logic [NCH*DW-1:0] pcm_in;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_chan;
    logic              m_last;
    logic              overrun;
    logic              ovr_clr;
    logic              busy;

    mic_frame_sched #(
        .NCH (NCH),
        .DW  (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .warmup_frames (warmup_frames),
        .ch_mask       (ch_mask),
        .ce_pcm        (ce_pcm),
        .pcm_in        (pcm_in),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_chan        (m_chan),
        .m_last        (m_last),
        .overrun       (overrun),
        .ovr_clr       (ovr_clr),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] d;
        logic        last;
    } beat_t;

    // Reference model: a queue of beats still owed for the current frame.
    beat_t exp_q[$];
    bit    idle_m = 1'b1;
    int    warm_m = 0;
    bit    ovr_m  = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int hs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        int hi;
        beat_t b;
        hi = -1;
        for (int i = 0; i < int'(NCH); i++) if (ch_mask[i]) hi = i;
        for (int i = 0; i < int'(NCH); i++) begin
            if (ch_mask[i]) begin
                b.ch   = 2'(i);
                b.d    = pcm_in[i*DW +: DW];
                b.last = (i == hi);
                exp_q.push_back(b);
            end
        end
    endtask

    // Check outputs for this cycle, advance the model over the coming edge.
    task automatic tick();
        bit draining;
        draining = (exp_q.size() > 0);
        chk("m_valid", {31'd0, m_valid}, {31'd0, draining});
        if (draining) begin
            chk("m_chan", {30'd0, m_chan}, {30'd0, exp_q[0].ch});
            chk("m_data", {16'd0, m_data}, {16'd0, exp_q[0].d});
            chk("m_last", {31'd0, m_last}, {31'd0, exp_q[0].last});
        end
        chk("overrun", {31'd0, overrun}, {31'd0, ovr_m});
        chk("busy", {31'd0, busy}, {31'd0, (!idle_m && (warm_m > 0 || draining))});
        if (m_valid && m_ready) hs_cnt++;

        if (rst) begin
            idle_m = 1'b1;
            warm_m = 0;
            ovr_m  = 1'b0;
            exp_q.delete();
        end else begin
            ovr_m = (draining && ce_pcm) || (ovr_m && !ovr_clr);
            if (!en) begin
                idle_m = 1'b1;
                exp_q.delete();
            end else if (idle_m) begin
                idle_m = 1'b0;
                warm_m = int'(warmup_frames);
            end else if (warm_m > 0) begin
                if (ce_pcm) warm_m--;
            end else if (draining) begin
                if (m_ready) void'(exp_q.pop_front());
            end else if (ce_pcm && ch_mask != '0) begin
                push_frame();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int gap);
        ce_pcm = 1'b1;
        pcm_in = {$urandom(), $urandom()};
        tick();
        ce_pcm = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, "_m_data"}, {16'd0, m_data}, 32'd0);
        chk({tag, "_m_chan"}, {30'd0, m_chan}, 32'd0);
        chk({tag, "_m_last"}, {31'd0, m_last}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; warmup_frames = 8'd0; ch_mask = '0;
        ce_pcm = 1'b0; pcm_in = '0; m_ready = 1'b0; ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_values("reset");
        rst = 1'b0;
        tick();

        // Warm-up of three frames, then two full frames.
        warmup_frames = 8'd3; ch_mask = 4'b1111; m_ready = 1'b1; en = 1'b1;
        tick();
        hs_cnt = 0;
        for (int f = 0; f < 5; f++) strobe(7);
        chk("warmup_beats", hs_cnt, 32'd8);

        // Sparse mask: exactly channels 1 and 3.
        ch_mask = 4'b1010; hs_cnt = 0;
        ce_pcm = 1'b1;
        pcm_in = {16'h00D3, 16'h00C2, 16'h00B1, 16'h00A0};
        tick();
        ce_pcm = 1'b0;
        repeat (5) tick();
        chk("sparse_beats", hs_cnt, 32'd2);

        // Stall for 10 cycles with a second strobe mid-drain.
        ch_mask = 4'b1111; m_ready = 1'b0; hs_cnt = 0;
        strobe(3);
        strobe(5);
        m_ready = 1'b1;
        repeat (6) tick();
        chk("stall_beats", hs_cnt, 32'd4);

        // Clear, then a strobe landing on the final handshake.
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        strobe(3);
        strobe(3);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        tick();

        // Empty mask ignored; single-channel mask gives one last beat.
        ch_mask = 4'b0000; hs_cnt = 0;
        strobe(2);
        strobe(2);
        chk("empty_beats", hs_cnt, 32'd0);
        ch_mask = 4'b0001;
        strobe(3);
        chk("single_beats", hs_cnt, 32'd1);

        // Enable drop mid-drain, re-enable with two warm-up frames.
        ch_mask = 4'b1111; m_ready = 1'b0;
        strobe(2);
        en = 1'b0;
        tick();
        tick();
        warmup_frames = 8'd2; en = 1'b1; m_ready = 1'b1;
        tick();
        hs_cnt = 0;
        for (int f = 0; f < 3; f++) strobe(6);
        chk("rewarm_beats", hs_cnt, 32'd4);

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            m_ready = ($urandom_range(3) != 0);
            ce_pcm  = ($urandom_range(5) == 0);
            pcm_in  = {$urandom(), $urandom()};
            if ($urandom_range(15) == 0) ch_mask = 4'($urandom());
            ovr_clr = ($urandom_range(19) == 0);
            if ($urandom_range(99) == 0) en = ~en;
            if (!en) warmup_frames = 8'($urandom_range(2));
            tick();
        end

        // Reset in the middle of a frame.
        en = 1'b1; ovr_clr = 1'b0; ce_pcm = 1'b0; m_ready = 1'b0; ch_mask = 4'b1111;
        repeat (4) tick();
        warmup_frames = 8'd0;
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        strobe(1);
        rst = 1'b1;
        tick();
        reset_values("midrst");
        rst = 1'b0;
        repeat (3) tick();

        if (fails != 0) $display("%0d comparisons disagreed", fails);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
